// File: rtl/hm_sched.sv
// Round-robin scheduler sharing one host-memory page-fetch engine between NREQ requesters.
// Grants a requester, issues page-aligned fetch starts, retries on timeout and reports done/error.
module hm_sched #(
  parameter int NREQ        = 4,
  parameter int MAX_RETRY   = 2,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                 trn_clk,
  input  logic                 trn_reset_n,
  input  logic                 trn_lnk_up_n,
  input  logic [NREQ-1:0]      req,
  input  logic [64*NREQ-1:0]   req_addr,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 hm_start,
  output logic [63:0]          hm_addr,
  input  logic                 hm_end,
  input  logic                 hm_tx_timeout,
  input  logic                 hm_rx_timeout,
  output logic [31:0]          stat_cpt_done,
  output logic [31:0]          stat_cpt_retry,
  output logic [31:0]          stat_cpt_err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_WAIT = 2'd2} state_e;

  state_e          state_q;
  logic [2:0]      ptr_q;
  logic [2:0]      grant_q;
  logic [7:0]      retry_q;
  logic [31:0]     wdog_q;
  logic            busy_q;
  logic            start_q;
  logic [63:0]     addr_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] err_q;
  logic [31:0]     done_cnt_q;
  logic [31:0]     retry_cnt_q;
  logic [31:0]     err_cnt_q;

  logic            win_found_s;
  logic [2:0]      win_idx_s;
  logic [63:0]     win_addr_s;
  logic [2:0]      ptr_d;
  logic [NREQ-1:0] grant_onehot_s;
  logic            wait_ok_s;
  logic            wait_fail_s;
  logic            wait_retry_s;

  // Round-robin winner: first set req bit scanning upward from the pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found_s && req[(int'(ptr_q) + i) % NREQ]) begin
        win_found_s = 1'b1;
        win_idx_s   = 3'((int'(ptr_q) + i) % NREQ);
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_addr_s = req_addr[int'(win_idx_s)*64 +: 64];
  end

  // Outcome of the current attempt while waiting on the engine.
  always_comb begin
    wait_ok_s    = 1'b0;
    wait_fail_s  = 1'b0;
    wait_retry_s = 1'b0;
    if (state_q != S_WAIT) begin
      wait_ok_s = 1'b0;
    end else if (trn_lnk_up_n) begin
      wait_fail_s = 1'b1;
    end else if (hm_end) begin
      wait_ok_s = 1'b1;
    end else if (hm_tx_timeout || hm_rx_timeout || (wdog_q == 32'(WDOG_CYCLES - 1))) begin
      if (retry_q < 8'(MAX_RETRY)) begin
        wait_retry_s = 1'b1;
      end else begin
        wait_fail_s = 1'b1;
      end
    end else begin
      wait_ok_s = 1'b0;
    end
    grant_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
    ptr_d          = (grant_q == 3'(NREQ - 1)) ? 3'd0 : grant_q + 3'd1;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd0;
      grant_q     <= 3'd0;
      retry_q     <= 8'd0;
      wdog_q      <= 32'd0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      addr_q      <= 64'd0;
      ack_q       <= '0;
      err_q       <= '0;
      done_cnt_q  <= 32'd0;
      retry_cnt_q <= 32'd0;
      err_cnt_q   <= 32'd0;
    end else begin
      ack_q   <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!trn_lnk_up_n && win_found_s) begin
            grant_q <= win_idx_s;
            addr_q  <= {win_addr_s[63:12], 12'h000};
            busy_q  <= 1'b1;
            retry_q <= 8'd0;
            state_q <= S_START;
          end
        end
        S_START: begin
          start_q <= 1'b1;
          wdog_q  <= 32'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_ok_s) begin
            ack_q      <= grant_onehot_s;
            done_cnt_q <= done_cnt_q + 32'd1;
            busy_q     <= 1'b0;
            ptr_q      <= ptr_d;
            state_q    <= S_IDLE;
          end else if (wait_fail_s) begin
            err_q     <= grant_onehot_s;
            err_cnt_q <= err_cnt_q + 32'd1;
            busy_q    <= 1'b0;
            ptr_q     <= ptr_d;
            state_q   <= S_IDLE;
          end else if (wait_retry_s) begin
            retry_q     <= retry_q + 8'd1;
            retry_cnt_q <= retry_cnt_q + 32'd1;
            state_q     <= S_START;
          end else begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack            = ack_q;
  assign err            = err_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
  assign hm_start       = start_q;
  assign hm_addr        = addr_q;
  assign stat_cpt_done  = done_cnt_q;
  assign stat_cpt_retry = retry_cnt_q;
  assign stat_cpt_err   = err_cnt_q;

endmodule

// File: tb/tb_hm_sched.sv
// Directed self-checking bench for hm_sched (NREQ=4, MAX_RETRY=2, WDOG_CYCLES=16).
module tb_hm_sched;

  logic         trn_clk = 1'b0;
  logic         trn_reset_n;
  logic         trn_lnk_up_n;
  logic [3:0]   req;
  logic [255:0] req_addr;
  logic [3:0]   ack;
  logic [3:0]   err;
  logic         busy;
  logic [2:0]   grant_id;
  logic         hm_start;
  logic [63:0]  hm_addr;
  logic         hm_end;
  logic         hm_tx_timeout;
  logic         hm_rx_timeout;
  logic [31:0]  stat_cpt_done;
  logic [31:0]  stat_cpt_retry;
  logic [31:0]  stat_cpt_err;

  int n_cmp = 0;
  int n_bad = 0;

  int cycle = 0;
  int start_cnt = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  int excl_bad = 0;

  hm_sched #(.NREQ(4), .MAX_RETRY(2), .WDOG_CYCLES(16)) dut (
    .trn_clk(trn_clk), .trn_reset_n(trn_reset_n), .trn_lnk_up_n(trn_lnk_up_n),
    .req(req), .req_addr(req_addr), .ack(ack), .err(err), .busy(busy),
    .grant_id(grant_id), .hm_start(hm_start), .hm_addr(hm_addr), .hm_end(hm_end),
    .hm_tx_timeout(hm_tx_timeout), .hm_rx_timeout(hm_rx_timeout),
    .stat_cpt_done(stat_cpt_done), .stat_cpt_retry(stat_cpt_retry), .stat_cpt_err(stat_cpt_err)
  );

  always #5 trn_clk = ~trn_clk;

  // Pulse monitor: counts starts/acks/errs and flags overlapping completion pulses.
  always @(negedge trn_clk) begin
    cycle <= cycle + 1;
    if (hm_start) start_cnt <= start_cnt + 1;
    if (ack != 4'd0) ack_cnt <= ack_cnt + 1;
    if (err != 4'd0) err_cnt <= err_cnt + 1;
    if ((ack | err) != 4'd0 && !$onehot(ack | err)) excl_bad <= excl_bad + 1;
  end

  task automatic cyc;
    @(negedge trn_clk);
    #1;
  endtask

  task automatic wait_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc();
      if (hm_start) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: no hm_start within 60 cycles", name);
    end
  endtask

  task automatic pulse_end;
    hm_end = 1'b1; cyc(); hm_end = 1'b0;
  endtask

  task automatic test_reset;
    trn_reset_n = 1'b0; trn_lnk_up_n = 1'b0; req = 4'd0; req_addr = '0;
    hm_end = 1'b0; hm_tx_timeout = 1'b0; hm_rx_timeout = 1'b0;
    repeat (3) cyc();
    trn_reset_n = 1'b1;
    cyc();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (hm_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %0b want 0", hm_start); end
    n_cmp++; if (grant_id !== 3'd0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    n_cmp++; if (hm_addr !== 64'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", hm_addr); end
    n_cmp++; if ({ack, err} !== 8'd0) begin n_bad++; $display("FAIL reset_ackerr: got %b want 0", {ack, err}); end
    n_cmp++;
    if ({stat_cpt_done, stat_cpt_retry, stat_cpt_err} !== 96'd0) begin
      n_bad++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", stat_cpt_done, stat_cpt_retry, stat_cpt_err);
    end
  endtask

  task automatic test_single;
    req_addr[64*1 +: 64] = 64'h0000_0001_2345_6ABC;
    req = 4'b0010;
    cyc();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %0b want 1", busy); end
    n_cmp++; if (hm_start !== 1'b0) begin n_bad++; $display("FAIL single_start_early: got %0b want 0", hm_start); end
    cyc();
    n_cmp++; if (hm_start !== 1'b1) begin n_bad++; $display("FAIL single_start: got %0b want 1", hm_start); end
    n_cmp++; if (hm_addr !== 64'h0000_0001_2345_6000) begin n_bad++; $display("FAIL single_addr: got %h want 0000000123456000", hm_addr); end
    n_cmp++; if (grant_id !== 3'd1) begin n_bad++; $display("FAIL single_grant: got %0d want 1", grant_id); end
    repeat (9) cyc();
    pulse_end();
    req = 4'd0;
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL single_ack: got %b want 0010", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %0b want 0", busy); end
    n_cmp++; if (stat_cpt_done !== 32'd1) begin n_bad++; $display("FAIL single_done: got %0d want 1", stat_cpt_done); end
    cyc();
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_id [5];
    logic [3:0] exp_ack;
    exp_id = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    trn_reset_n = 1'b0; cyc(); trn_reset_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start("rr_start");
      n_cmp++; if (grant_id !== exp_id[i]) begin n_bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, grant_id, exp_id[i]); end
      repeat (2) cyc();
      pulse_end();
      if (i == 4) req = 4'd0;
      exp_ack = 4'b0001 << exp_id[i];
      n_cmp++; if (ack !== exp_ack) begin n_bad++; $display("FAIL rr_ack[%0d]: got %b want %b", i, ack, exp_ack); end
    end
  endtask

  task automatic test_retry_success;
    int s0, a0, e0;
    s0 = start_cnt; a0 = ack_cnt; e0 = err_cnt;
    req_addr[63:0] = 64'hFEDC_BA98_7654_3210;
    req = 4'b0001;
    wait_start("retry_start1");
    n_cmp++; if (hm_addr !== 64'hFEDC_BA98_7654_3000) begin n_bad++; $display("FAIL retry_addr1: got %h want fedcba9876543000", hm_addr); end
    req_addr[63:0] = 64'h1111_2222_3333_4444;
    hm_tx_timeout = 1'b1; cyc(); hm_tx_timeout = 1'b0;
    wait_start("retry_start2");
    n_cmp++; if (hm_addr !== 64'hFEDC_BA98_7654_3000) begin n_bad++; $display("FAIL retry_addr2: got %h want fedcba9876543000", hm_addr); end
    hm_rx_timeout = 1'b1; cyc(); hm_rx_timeout = 1'b0;
    wait_start("retry_start3");
    n_cmp++; if (hm_addr !== 64'hFEDC_BA98_7654_3000) begin n_bad++; $display("FAIL retry_addr3: got %h want fedcba9876543000", hm_addr); end
    pulse_end();
    req = 4'd0;
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL retry_ack: got %b want 0001", ack); end
    repeat (3) cyc();
    n_cmp++; if (stat_cpt_retry !== 32'd2) begin n_bad++; $display("FAIL retry_stat: got %0d want 2", stat_cpt_retry); end
    n_cmp++; if (start_cnt - s0 !== 3) begin n_bad++; $display("FAIL retry_starts: got %0d want 3", start_cnt - s0); end
    n_cmp++; if (ack_cnt - a0 !== 1) begin n_bad++; $display("FAIL retry_acks: got %0d want 1", ack_cnt - a0); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL retry_errs: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_watchdog;
    int t [3];
    bit seen;
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      wait_start("wd_start");
      t[i] = cycle;
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (t[i] - t[i-1] < 17 || t[i] - t[i-1] > 18) begin
        n_bad++; $display("FAIL wd_spacing[%0d]: got %0d want 17..18", i, t[i] - t[i-1]);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (err != 4'd0) seen = 1'b1;
    end
    req = 4'b1111;
    n_cmp++; if (err !== 4'b0100) begin n_bad++; $display("FAIL wd_err: got %b want 0100", err); end
    n_cmp++; if (stat_cpt_err !== 32'd1) begin n_bad++; $display("FAIL wd_stat_err: got %0d want 1", stat_cpt_err); end
    n_cmp++; if (stat_cpt_retry !== 32'd4) begin n_bad++; $display("FAIL wd_stat_retry: got %0d want 4", stat_cpt_retry); end
    wait_start("wd_next");
    n_cmp++; if (grant_id !== 3'd3) begin n_bad++; $display("FAIL wd_ptr: got %0d want 3", grant_id); end
    pulse_end();
    req = 4'd0;
  endtask

  task automatic test_simultaneous;
    int s0;
    req = 4'b0010;
    wait_start("sim_start");
    hm_end = 1'b1; hm_rx_timeout = 1'b1; cyc(); hm_end = 1'b0; hm_rx_timeout = 1'b0;
    req = 4'd0;
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL sim_ack: got %b want 0010", ack); end
    s0 = start_cnt;
    repeat (4) cyc();
    n_cmp++; if (stat_cpt_retry !== 32'd4) begin n_bad++; $display("FAIL sim_retry: got %0d want 4", stat_cpt_retry); end
    n_cmp++; if (start_cnt !== s0) begin n_bad++; $display("FAIL sim_restart: got %0d starts want 0", start_cnt - s0); end
    req = 4'b0001;
    wait_start("link_start");
    trn_lnk_up_n = 1'b1;
    cyc();
    n_cmp++; if (err !== 4'b0001) begin n_bad++; $display("FAIL link_err: got %b want 0001", err); end
    n_cmp++; if (stat_cpt_err !== 32'd2) begin n_bad++; $display("FAIL link_stat_err: got %0d want 2", stat_cpt_err); end
    n_cmp++; if (stat_cpt_retry !== 32'd4) begin n_bad++; $display("FAIL link_retry: got %0d want 4", stat_cpt_retry); end
    s0 = start_cnt;
    repeat (5) cyc();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL linkdown_busy: got %0b want 0", busy); end
    n_cmp++; if (start_cnt !== s0) begin n_bad++; $display("FAIL linkdown_start: got %0d starts want 0", start_cnt - s0); end
    req = 4'd0;
    trn_lnk_up_n = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_wait;
    int a0, e0;
    req = 4'b0100;
    wait_start("rst_start");
    #2 trn_reset_n = 1'b0;
    #1;
    a0 = ack_cnt; e0 = err_cnt;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_cmp++; if (hm_start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %0b want 0", hm_start); end
    n_cmp++; if (stat_cpt_done !== 32'd0) begin n_bad++; $display("FAIL rst_done: got %0d want 0", stat_cpt_done); end
    n_cmp++; if (stat_cpt_err !== 32'd0) begin n_bad++; $display("FAIL rst_err: got %0d want 0", stat_cpt_err); end
    cyc();
    trn_reset_n = 1'b1;
    req = 4'b1111;
    wait_start("rst_next");
    n_cmp++; if (grant_id !== 3'd0) begin n_bad++; $display("FAIL rst_ptr: got %0d want 0", grant_id); end
    n_cmp++; if (ack_cnt !== a0 || err_cnt !== e0) begin n_bad++; $display("FAIL rst_noack: got %0d acks %0d errs want 0 0", ack_cnt - a0, err_cnt - e0); end
    pulse_end();
    req = 4'd0;
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL rst_ack: got %b want 0001", ack); end
    cyc();
  endtask

  task automatic test_exclusive;
    n_cmp++; if (excl_bad !== 0) begin n_bad++; $display("FAIL ack_err_exclusive: got %0d overlaps want 0", excl_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_retry_success();
    test_watchdog();
    test_simultaneous();
    test_reset_mid_wait();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
